ram_rw_ctrl: RTL and testbench
==============================

RAM_RW_CTRL -- requirements
Module: ram_rw_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5: RAM address width; depth DEPTH = 2**ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: RAM data width.
REQ-003 SHALL have parameter RD_LATENCY, default 1, legal 1..2: clocks from ram_addr presented to ram_rd_data valid.
REQ-004 SHALL have parameter DATA_SEED, default 8'h00: pattern offset.
REQ-005 SHALL have one clock and an asynchronous, active-low reset; all ports follow.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 start  in  1  run request, sampled in IDLE only.
REQ-009 ram_addr  out  ADDR_WIDTH  address to single-port RAM.
REQ-010 ram_wr_data  out  DATA_WIDTH  write data to RAM.
REQ-011 ram_wr_en  out  1  RAM write enable, high = write.
REQ-012 ram_rd_data  in  DATA_WIDTH  RAM read data.
REQ-013 rd_valid  out  1  rd_data_out holds a returned word this cycle.
REQ-014 rd_data_out  out  DATA_WIDTH  captured read word.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-cycle pulse at end of run.
REQ-017 err  out  1  sticky mismatch flag.

Function
REQ-018 SHALL implement FSM IDLE -> WRITE -> READ -> DRAIN -> DONE -> IDLE.
REQ-019 IDLE: start high at an edge -> WRITE; start while busy SHALL be ignored (no restart, no queuing).
REQ-020 WRITE: one write per clock, ram_wr_en=1, ram_addr 0..DEPTH-1 ascending, ram_wr_data = (ram_addr + DATA_SEED) mod 2**DATA_WIDTH; after address DEPTH-1 -> READ.
REQ-021 READ: ram_wr_en=0, ram_addr 0..DEPTH-1 one per clock; after address DEPTH-1 -> DRAIN.
REQ-022 DRAIN: lasts RD_LATENCY clocks so every issued read returns; then -> DONE.
REQ-023 DONE: done=1 for exactly one clock, then IDLE.
REQ-024 Address counter SHALL wrap DEPTH-1 -> 0 at each phase boundary; no extra or skipped address.
REQ-025 Read-return tracking SHALL use a RD_LATENCY-deep valid/address shift pipeline; rd_valid high exactly DEPTH clocks per run, first RD_LATENCY clocks after first read address.
REQ-026 rd_data_out SHALL equal ram_rd_data sampled in the same cycle rd_valid is high (registered one cycle later is forbidden).
REQ-027 Outside WRITE: ram_wr_en=0; ram_addr and ram_wr_data hold last values in IDLE.
REQ-028 Total run: done high 2*DEPTH+RD_LATENCY+1 clocks after the edge sampling start (66 for defaults).
REQ-029 err SHALL clear on accepted start and set on any mismatch; it holds through IDLE.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, ram_addr=0, ram_wr_data=0, ram_wr_en=0, rd_valid=0, rd_data_out=0, busy=0, done=0, err=0, pipelines cleared.
REQ-031 Reset mid-run SHALL abort with no done pulse; next start SHALL begin a full run from address 0.
REQ-032 Release SHALL be synchronised externally; block adds no reset synchroniser.

Configuration
REQ-033 Macro RAM_RW_CHECK_EN defined: each valid word compared with (returned address + DATA_SEED); mismatch sets err in the next clock.
REQ-034 RAM_RW_CHECK_EN undefined: no compare logic; err tied 0; all other behaviour identical.

Structure
REQ-035 Shared package ram_rw_pkg SHALL hold FSM state enum and default widths/DEPTH constants.
REQ-036 Sub-module ram_rd_pipe SHALL implement the RD_LATENCY valid/address shift pipeline; no other sub-modules.

Verification
REQ-037 Defaults, behavioural 32x8 RAM latency 1, one start pulse -> 32 writes data 0x00..0x1F, 32 rd_valid with rd_data_out 0x00..0x1F, done at clock 66, err=0.
REQ-038 start held high continuously -> runs back-to-back with one IDLE clock between done and next WRITE; no start accepted while busy=1.
REQ-039 RAM model corrupts address 0x0A to 0x55, RAM_RW_CHECK_EN defined -> err=1 one clock after that word, stays 1 after done; next start clears err.
REQ-040 rst_n low during READ at address 0x10 -> all outputs reset values same clock, no done; next start produces full clean run.
REQ-041 RD_LATENCY=2, DATA_SEED=8'hA0 -> rd_data_out 0xA0..0xBF, done at clock 67.
REQ-042 RAM_RW_CHECK_EN undefined with corrupted word -> err stays 0, rd_data_out shows 0x55 at address 0x0A.

Source files
------------

// File: rtl/ram_rw_pkg.sv
// rtl/ram_rw_pkg.sv - shared FSM state encoding and default sizing for ram_rw_ctrl
package ram_rw_pkg;

    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH      = 2 ** DEF_ADDR_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/ram_rd_pipe.sv
// rtl/ram_rd_pipe.sv - RD_LATENCY-deep valid/address shift pipeline tracking outstanding RAM reads
module ram_rd_pipe #(
    parameter int ADDR_WIDTH = 5,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue_valid_i,
    input  logic [ADDR_WIDTH-1:0] issue_addr_i,
    output logic                  ret_valid_o,
    output logic [ADDR_WIDTH-1:0] ret_addr_o
);

    logic [RD_LATENCY-1:0]                 valid_q;
    logic [RD_LATENCY-1:0][ADDR_WIDTH-1:0] addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            addr_q  <= '0;
        end else begin
            valid_q[0] <= issue_valid_i;
            addr_q[0]  <= issue_addr_i;
            for (int i = 1; i < RD_LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                addr_q[i]  <= addr_q[i-1];
            end
        end
    end

    assign ret_valid_o = valid_q[RD_LATENCY-1];
    assign ret_addr_o  = addr_q[RD_LATENCY-1];

endmodule

// File: rtl/ram_rw_ctrl.sv
// rtl/ram_rw_ctrl.sv - RAM write/read-back sequencer; define RAM_RW_CHECK_EN to add the read-data checker
module ram_rw_ctrl
    import ram_rw_pkg::*;
#(
    parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int                    RD_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] DATA_SEED  = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic                  ram_wr_en,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data_out,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = '1;
    localparam logic [1:0]            DRAIN_LAST = 2'(RD_LATENCY - 1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [1:0]            drain_q, drain_d;
    logic [DATA_WIDTH-1:0] hold_q;
    logic                  ret_valid;
    logic [ADDR_WIDTH-1:0] ret_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            drain_q <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            drain_q <= drain_d;
            if (ret_valid) begin
                hold_q <= ram_rd_data;
            end
        end
    end

    // Address wraps to 0 on every phase change so each phase starts clean.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        drain_d = drain_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_WRITE;
                    addr_d  = '0;
                    wdata_d = DATA_SEED;
                end
            end
            ST_WRITE: begin
                if (addr_q == ADDR_LAST) begin
                    state_d = ST_READ;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                end
                wdata_d = DATA_WIDTH'(addr_d) + DATA_SEED;
            end
            ST_READ: begin
                if (addr_q == ADDR_LAST) begin
                    state_d = ST_DRAIN;
                    addr_d  = '0;
                    drain_d = '0;
                end else begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    ram_rd_pipe #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_pipe (
        .clk           (clk),
        .rst_n         (rst_n),
        .issue_valid_i (state_q == ST_READ),
        .issue_addr_i  (addr_q),
        .ret_valid_o   (ret_valid),
        .ret_addr_o    (ret_addr)
    );

    assign ram_addr    = addr_q;
    assign ram_wr_data = wdata_q;
    assign ram_wr_en   = (state_q == ST_WRITE);
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign rd_valid    = ret_valid;
    // Returned word passes straight through in its valid cycle; hold_q only keeps it visible afterwards.
    assign rd_data_out = ret_valid ? ram_rd_data : hold_q;

`ifdef RAM_RW_CHECK_EN
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] expect_data;

    assign expect_data = DATA_WIDTH'(ret_addr) + DATA_SEED;

    always_comb begin
        err_d = err_q;
        if (state_q == ST_IDLE && start) begin
            err_d = 1'b0;
        end else if (ret_valid && (ram_rd_data != expect_data)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_ret_addr;
    assign unused_ret_addr = ^ret_addr;
    assign err             = 1'b0;
`endif

endmodule

// File: tb/tb_ram_rw_ctrl.sv
// tb/tb_ram_rw_ctrl.sv - scoreboard bench for ram_rw_ctrl (default and RD_LATENCY=2/seed 0xA0 instances)
module tb_ram_rw_ctrl;

    localparam int AW    = 5;
    localparam int DW    = 8;
    localparam int DEPTH = 32;
`ifdef RAM_RW_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          start_a, wen_a, rv_a, busy_a, done_a, err_a;
    logic [AW-1:0] addr_a;
    logic [DW-1:0] wdata_a, rdata_a, rdo_a;
    logic          start_b, wen_b, rv_b, busy_b, done_b, err_b;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] wdata_b, rdata_b, rdo_b, rb1;
    logic          corrupt;
    logic [DW-1:0] mem_a [DEPTH];
    logic [DW-1:0] mem_b [DEPTH];

    ram_rw_ctrl dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .ram_addr(addr_a), .ram_wr_data(wdata_a),
        .ram_wr_en(wen_a), .ram_rd_data(rdata_a), .rd_valid(rv_a), .rd_data_out(rdo_a),
        .busy(busy_a), .done(done_a), .err(err_a)
    );

    ram_rw_ctrl #(.RD_LATENCY(2), .DATA_SEED(8'hA0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .ram_addr(addr_b), .ram_wr_data(wdata_b),
        .ram_wr_en(wen_b), .ram_rd_data(rdata_b), .rd_valid(rv_b), .rd_data_out(rdo_b),
        .busy(busy_b), .done(done_b), .err(err_b)
    );

    always @(posedge clk) begin
        if (wen_a) mem_a[addr_a] <= wdata_a;
        rdata_a <= (corrupt && addr_a == 5'h0A) ? 8'h55 : mem_a[addr_a];
        if (wen_b) mem_b[addr_b] <= wdata_b;
        rb1     <= mem_b[addr_b];
        rdata_b <= rb1;
    end

    int wq_a[$];
    int rq_a[$];
    int dq_a[$];
    int wq_b[$];
    int rq_b[$];
    int dq_b[$];
    int ea, eb;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_run(input bit side_b, input int st, input bit corr);
        int seed = side_b ? 'hA0 : 0;
        int lat  = side_b ? 2 : 1;
        for (int i = 0; i < DEPTH; i++) begin
            int d = (i + seed) & 'hFF;
            int e = (CHK && corr && i > 'h0A) ? 1 : 0;
            int w = (i << 8) | d;
            if (corr && i == 'h0A) d = 'h55;
            if (side_b) begin
                wq_b.push_back(w);
                rq_b.push_back((e << 8) | d);
            end else begin
                wq_a.push_back(w);
                rq_a.push_back((e << 8) | d);
            end
        end
        if (side_b) dq_b.push_back(st + 2 * DEPTH + lat);
        else        dq_a.push_back(st + 2 * DEPTH + lat);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (wen_a) begin
                check("a_write_expected", 32'(wq_a.size() != 0), 1);
                if (wq_a.size() != 0) begin
                    ea = wq_a.pop_front();
                    check("a_write_addr_data", 32'({addr_a, wdata_a}), ea);
                end
            end
            if (rv_a) begin
                check("a_read_expected", 32'(rq_a.size() != 0), 1);
                check("a_rd_same_cycle", 32'(rdo_a), 32'(rdata_a));
                if (rq_a.size() != 0) begin
                    ea = rq_a.pop_front();
                    check("a_rd_data", 32'(rdo_a), ea & 'hFF);
                    check("a_err_at_read", 32'(err_a), (ea >> 8) & 1);
                end
            end
            if (done_a) begin
                check("a_done_expected", 32'(dq_a.size() != 0), 1);
                if (dq_a.size() != 0) begin
                    ea = dq_a.pop_front();
                    check("a_done_cycle", cyc, ea);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (wen_b) begin
                check("b_write_expected", 32'(wq_b.size() != 0), 1);
                if (wq_b.size() != 0) begin
                    eb = wq_b.pop_front();
                    check("b_write_addr_data", 32'({addr_b, wdata_b}), eb);
                end
            end
            if (rv_b) begin
                check("b_read_expected", 32'(rq_b.size() != 0), 1);
                check("b_rd_same_cycle", 32'(rdo_b), 32'(rdata_b));
                if (rq_b.size() != 0) begin
                    eb = rq_b.pop_front();
                    check("b_rd_data", 32'(rdo_b), eb & 'hFF);
                    check("b_err_at_read", 32'(err_b), (eb >> 8) & 1);
                end
            end
            if (done_b) begin
                check("b_done_expected", 32'(dq_b.size() != 0), 1);
                if (dq_b.size() != 0) begin
                    eb = dq_b.pop_front();
                    check("b_done_cycle", cyc, eb);
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_a"}, 32'({addr_a, wdata_a, wen_a, rv_a, rdo_a, busy_a, done_a, err_a}), 0);
        check({tag, "_b"}, 32'({addr_b, wdata_b, wen_b, rv_b, rdo_b, busy_b, done_b, err_b}), 0);
    endtask

    task automatic start_run(input bit use_a, input bit use_b, input bit corr);
        @(negedge clk);
        corrupt = corr;
        start_a = use_a;
        start_b = use_b;
        @(posedge clk);
        #1;
        if (use_a) push_run(1'b0, cyc, corr);
        if (use_b) push_run(1'b1, cyc, 1'b0);
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy_a || busy_b || dq_a.size() != 0 || dq_b.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(n < 400), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (checks %0d)", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst_n   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        corrupt = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_state");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // clean runs on both instances together
        start_run(1'b1, 1'b1, 1'b0);
        wait_idle("run1_completes");
        check("run1_err_clear", 32'(err_a), 0);
        check("run1_b_last_word", 32'(rdo_b), 32'hBF);

        // start held high: back-to-back runs with one IDLE clock between
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        push_run(1'b0, cyc, 1'b0);
        push_run(1'b0, cyc + 2 * DEPTH + 3, 1'b0);
        n = 0;
        while (!done_a && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("b2b_first_done_seen", 32'(n < 200), 1);
        @(negedge clk);
        check("b2b_idle_gap", 32'(busy_a), 0);
        @(negedge clk);
        check("b2b_restart_write0", 32'({busy_a, wen_a, addr_a}), 32'h60);
        start_a = 1'b0;
        wait_idle("b2b_completes");

        // corrupted word at 0x0A, then a clean run clears err
        start_run(1'b1, 1'b0, 1'b1);
        wait_idle("corrupt_run_completes");
        check("err_held_after_done", 32'(err_a), 32'(CHK));
        start_run(1'b1, 1'b0, 1'b0);
        check("err_cleared_on_start", 32'(err_a), 0);
        wait_idle("clean_after_corrupt_completes");

        // reset while READ presents address 0x10
        start_run(1'b1, 1'b0, 1'b0);
        n = 0;
        while (!(busy_a && !wen_a && addr_a == 5'h10) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reach_read_0x10", 32'(n < 200), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset_mid_read");
        wq_a.delete();
        rq_a.delete();
        dq_a.delete();
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_after_abort", 32'({busy_a, done_a}), 0);
        start_run(1'b1, 1'b0, 1'b0);
        wait_idle("run_after_reset_completes");

        check("a_queues_empty", wq_a.size() + rq_a.size() + dq_a.size(), 0);
        check("b_queues_empty", wq_b.size() + rq_b.size() + dq_b.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
